product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter width, default 8, giving the operand width of the upstream Multiplier; products are 2*width bits.
REQ-002 SHALL have parameter count, default 4, giving the number of products summed per result; legal range 1..255.
REQ-003 SHALL have parameter guard, default 2, giving the extra accumulator bits above 2*width; acc width = 2*width+guard.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a single-cycle request that clears the accumulator and begins a new sum.
REQ-007 SHALL have port prod, input, 2*width, the unsigned product from the Multiplier.
REQ-008 SHALL have port prod_valid, input, 1, meaning prod holds a product to accept.
REQ-009 SHALL have port prod_ready, output, 1, meaning the block accepts prod this cycle.
REQ-010 SHALL have port sum, output, 2*width+guard, the accumulated unsigned result.
REQ-011 SHALL have port sum_valid, output, 1, meaning sum holds a completed result.
REQ-012 SHALL have port sum_ready, input, 1, meaning the consumer takes sum this cycle.
REQ-013 SHALL have port overflow, output, 1, a sticky flag set when a carry leaves the accumulator during the current sum.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACC and HOLD, encoded as a state register.
REQ-016 In IDLE, start=1 SHALL clear sum, overflow and the product counter, then enter ACC on the next edge.
REQ-017 In IDLE, prod_ready SHALL be 0 and prod_valid SHALL be ignored.
REQ-018 In ACC, prod_ready SHALL be 1, driven combinationally from the state.
REQ-019 A product is accepted when prod_valid=1 and prod_ready=1 on a rising edge; zero-extended prod is then added to sum.
REQ-020 Addition SHALL be modulo 2^(2*width+guard); a carry out SHALL set overflow, which stays set until the next accepted start or reset.
REQ-021 The counter SHALL increment once per accepted product.
REQ-022 When the count-th product is accepted, the FSM SHALL enter HOLD on that same edge, with sum already including that product, i.e. 1-cycle latency from the last accept to sum_valid.
REQ-023 In HOLD, sum_valid SHALL be 1, sum and overflow SHALL stay stable, and prod_ready SHALL be 0.
REQ-024 In HOLD, sum_valid=1 with sum_ready=1 on an edge SHALL return the FSM to IDLE, and sum_valid SHALL drop on the next cycle.
REQ-025 While sum_ready=0, HOLD SHALL persist indefinitely.
REQ-026 sum SHALL keep its last value in IDLE until the next start.
REQ-027 start SHALL be ignored in ACC and HOLD, with no clear and no restart.
REQ-028 A start pulse in the same cycle as the HOLD-to-IDLE handshake SHALL be ignored; start is only sampled in IDLE.
REQ-029 prod_valid=0 cycles in ACC SHALL leave sum and the counter unchanged.
REQ-030 With count=1, the first accepted product SHALL move the FSM directly to HOLD.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, sum=0, counter=0, overflow=0, sum_valid=0, prod_ready=0 and busy=0.
REQ-032 A reset asserted mid-ACC or mid-HOLD SHALL discard the partial or held sum with no output handshake.
REQ-033 After rst_n deasserts, the first start SHALL be honoured on the first rising edge where rst_n=1.

Verification
REQ-034 Defaults: start, then products 0x0000, 0x00C3, 0x0082, 0xFE01, one per cycle -> sum=0x0FF46, overflow=0, sum_valid 1 cycle after the 4th accept.
REQ-035 Bubbles: same products with prod_valid=0 for 2 cycles between each -> identical sum; no acceptance while prod_valid=0.
REQ-036 Back-pressure: sum_ready=0 for 5 cycles in HOLD -> sum_valid=1 and sum stable all 5 cycles, prod_ready=0 while prod_valid=1; sum_ready=1 -> IDLE.
REQ-037 Overflow: guard=0, count=2, products 0xFE01 and 0xFE01 -> sum=0xFC02, overflow=1; next start clears overflow to 0.
REQ-038 Reset mid-op: rst_n=0 after 2 accepts -> sum=0, sum_valid=0 and busy=0 before the next clk edge; a fresh sum then completes correctly.
REQ-039 Ignored start: start pulses during ACC and HOLD -> no effect on sum or the counter.

Source files
------------

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a fixed number of unsigned products coming from an upstream
// Multiplier and presents the total to a downstream consumer using a
// valid/ready handshake on both sides.
//
// Parameters
//   width : operand width of the upstream Multiplier (products are 2*width)
//   count : number of products summed per result (1..255)
//   guard : extra accumulator bits above 2*width
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   start      : single-cycle request; clears the sum and begins a new one
//   prod       : unsigned product from the Multiplier
//   prod_valid : prod holds a product to accept
//   prod_ready : the block accepts prod this cycle (high only while summing)
//   sum        : accumulated unsigned result
//   sum_valid  : sum holds a completed result
//   sum_ready  : consumer takes sum this cycle
//   overflow   : sticky flag, a carry left the accumulator during this sum
//   busy       : high whenever the block is not idle
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int width = 8,
    parameter int count = 4,
    parameter int guard = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2*width-1:0]       prod,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic [2*width+guard-1:0] sum,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     overflow,
    output logic                     busy
);

    localparam int PW = 2 * width;
    localparam int SW = 2 * width + guard;

    // Index of the final product of a sum; counter is 8 bits since count <= 255.
    localparam logic [7:0] LAST = 8'(count - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      cnt_q, cnt_d;

    // One extra bit on the adder captures the carry that leaves the accumulator.
    logic [SW:0]     add_full;

    assign add_full = {1'b0, sum_q} + {{(SW + 1 - PW){1'b0}}, prod};

    // Next-state and output decode. Handshake outputs depend only on the state,
    // so an asynchronous reset of the state drops them immediately.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        prod_ready = 1'b0;
        sum_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d      = '0;
                    overflow_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ACC;
                end
            end
            ACC: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    sum_d      = add_full[SW-1:0];
                    overflow_d = overflow_q | add_full[SW];
                    cnt_d      = cnt_q + 8'd1;
                    // Leaving on the final accept means sum_valid follows that
                    // product by exactly one cycle.
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sum_valid = 1'b1;
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Self-checking bench for product_accumulator. Two instances are used: one
// with default parameters and one with guard=0, count=2 to exercise the
// overflow path. Expected results are pushed to a queue as products are
// driven and popped when the DUT raises sum_valid.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   typedef struct {
      logic [17:0] sum;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;

   // default instance: width 8, count 4, guard 2
   logic        start;
   logic [15:0] prod;
   logic        prod_valid;
   logic        prod_ready;
   logic [17:0] sum;
   logic        sum_valid;
   logic        sum_ready;
   logic        overflow;
   logic        busy;

   // overflow instance: width 8, count 2, guard 0
   logic        start2;
   logic [15:0] prod2;
   logic        prod_valid2;
   logic        prod_ready2;
   logic [15:0] sum2;
   logic        sum_valid2;
   logic        sum_ready2;
   logic        overflow2;
   logic        busy2;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   exp_t        exp2_q[$];
   logic [63:0] ref_acc;
   logic [15:0] prods [4];

   product_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .sum        (sum),
      .sum_valid  (sum_valid),
      .sum_ready  (sum_ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   product_accumulator #(.width(8), .count(2), .guard(0)) dut_ov (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start2),
      .prod       (prod2),
      .prod_valid (prod_valid2),
      .prod_ready (prod_ready2),
      .sum        (sum2),
      .sum_valid  (sum_valid2),
      .sum_ready  (sum_ready2),
      .overflow   (overflow2),
      .busy       (busy2)
   );

   // free-running clock, first rising edge at 5
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // hard time limit so a stuck run still ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive n products (one per cycle, optional bubbles), updating the model
   task automatic feed(input int n, input int bubbles, input bit push);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         prod       = prods[i % 4];
         prod_valid = 1'b1;
         tick();
         ref_acc    = ref_acc + 64'(prods[i % 4]);
         prod_valid = 1'b0;
         if (i < n - 1) begin
            for (int b = 0; b < bubbles; b++) begin
               prod = 16'hFFFF;
               tick();
            end
         end
      end
      if (push) begin
         e.sum = ref_acc[17:0];
         e.ovf = (ref_acc >> 18) != 64'd0;
         exp_q.push_back(e);
      end
   endtask

   // asynchronous reset takes effect before any clock edge
   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #2;
      checks++;
      if (sum !== 18'h0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_sum: got sum=%h ovf=%b want sum=0 ovf=0", sum, overflow);
      end
      checks++;
      if ({sum_valid, prod_ready, busy} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got valid/ready/busy=%b want 000", {sum_valid, prod_ready, busy});
      end
      checks++;
      if ({sum_valid2, prod_ready2, busy2, overflow2} !== 4'b0000 || sum2 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_ov_inst: got ctrl=%b sum=%h want 0000 0", {sum_valid2, prod_ready2, busy2, overflow2}, sum2);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // back-to-back products, latency and return to idle
   task automatic test_basic();
      exp_t e;
      ref_acc = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, prod_ready} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL basic_enter_acc: got busy/ready=%b want 11", {busy, prod_ready});
      end
      for (int i = 0; i < 4; i++) begin
         prod       = prods[i];
         prod_valid = 1'b1;
         tick();
         ref_acc = ref_acc + 64'(prods[i]);
         checks++;
         if (sum !== ref_acc[17:0]) begin
            errors++;
            $display("[TB] FAIL basic_running_sum: got %h want %h", sum, ref_acc[17:0]);
         end
         if (i < 3) begin
            checks++;
            if (sum_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL basic_early_valid: got %b want 0", sum_valid);
            end
         end
      end
      prod_valid = 1'b0;
      e.sum = ref_acc[17:0];
      e.ovf = (ref_acc >> 18) != 64'd0;
      exp_q.push_back(e);
      checks++;
      if (sum_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL basic_latency: got sum_valid=%b want 1", sum_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (sum !== e.sum || overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL basic_result: got sum=%h ovf=%b want sum=%h ovf=%b", sum, overflow, e.sum, e.ovf);
         end
      end
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      checks++;
      if ({sum_valid, busy} !== 2'b00 || sum !== e.sum) begin
         errors++;
         $display("[TB] FAIL basic_idle_keep: got valid/busy=%b sum=%h want 00 sum=%h", {sum_valid, busy}, sum, e.sum);
      end
   endtask

   // two idle cycles between products with junk on prod
   task automatic test_bubbles();
      exp_t e;
      ref_acc = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         prod       = prods[i];
         prod_valid = 1'b1;
         tick();
         ref_acc    = ref_acc + 64'(prods[i]);
         prod_valid = 1'b0;
         if (i < 3) begin
            for (int b = 0; b < 2; b++) begin
               prod = 16'hFFFF;
               tick();
               checks++;
               if (sum !== ref_acc[17:0] || sum_valid !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL bubble_no_accept: got sum=%h valid=%b want sum=%h valid=0", sum, sum_valid, ref_acc[17:0]);
               end
            end
         end
      end
      e.sum = ref_acc[17:0];
      e.ovf = (ref_acc >> 18) != 64'd0;
      exp_q.push_back(e);
      checks++;
      if (sum_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL bubble_valid: got sum_valid=%b want 1", sum_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (sum !== e.sum || overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL bubble_result: got sum=%h ovf=%b want sum=%h ovf=%b", sum, overflow, e.sum, e.ovf);
         end
      end
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
   endtask

   // consumer stalls five cycles while the Multiplier keeps offering data
   task automatic test_back_pressure();
      exp_t e;
      ref_acc = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      feed(4, 0, 1'b1);
      if (sum_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else begin
         e.sum = ref_acc[17:0];
         e.ovf = 1'b0;
         errors++;
         $display("[TB] FAIL bp_no_result: got sum_valid=%b want 1", sum_valid);
      end
      checks++;
      prod       = 16'h1111;
      prod_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({sum_valid, prod_ready} !== 2'b10 || sum !== e.sum) begin
            errors++;
            $display("[TB] FAIL bp_hold: got valid/ready=%b sum=%h want 10 sum=%h", {sum_valid, prod_ready}, sum, e.sum);
         end
      end
      prod_valid = 1'b0;
      sum_ready  = 1'b1;
      tick();
      sum_ready = 1'b0;
      checks++;
      if ({busy, sum_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL bp_release: got busy/valid=%b want 00", {busy, sum_valid});
      end
   endtask

   // start pulses in ACC, in HOLD and during the release handshake
   task automatic test_ignored_start();
      exp_t e;
      ref_acc = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         prod       = prods[(i + 1) % 4];
         prod_valid = 1'b1;
         tick();
         ref_acc    = ref_acc + 64'(prods[(i + 1) % 4]);
         prod_valid = 1'b0;
         if (i == 1) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (sum !== ref_acc[17:0] || busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL start_in_acc: got sum=%h busy=%b want sum=%h busy=1", sum, busy, ref_acc[17:0]);
            end
         end
      end
      e.sum = ref_acc[17:0];
      e.ovf = (ref_acc >> 18) != 64'd0;
      exp_q.push_back(e);
      checks++;
      if (sum_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL start_count_kept: got sum_valid=%b want 1", sum_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (sum !== e.sum) begin
            errors++;
            $display("[TB] FAIL start_acc_result: got %h want %h", sum, e.sum);
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (sum_valid !== 1'b1 || sum !== e.sum) begin
         errors++;
         $display("[TB] FAIL start_in_hold: got valid=%b sum=%h want 1 sum=%h", sum_valid, sum, e.sum);
      end
      start     = 1'b1;
      sum_ready = 1'b1;
      tick();
      start     = 1'b0;
      sum_ready = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || sum !== e.sum) begin
         errors++;
         $display("[TB] FAIL start_on_handshake: got busy=%b sum=%h want 0 sum=%h", busy, sum, e.sum);
      end
   endtask

   // guard=0, count=2 instance wraps and flags the carry
   task automatic test_overflow();
      exp_t        e;
      logic [63:0] ref2;
      ref2   = 64'd0;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prod2       = 16'hFE01;
         prod_valid2 = 1'b1;
         tick();
         ref2 = ref2 + 64'h0000_0000_0000_FE01;
      end
      prod_valid2 = 1'b0;
      e.sum = {2'b00, ref2[15:0]};
      e.ovf = (ref2 >> 16) != 64'd0;
      exp2_q.push_back(e);
      checks++;
      if (sum_valid2 !== 1'b1 || exp2_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL ovf_valid: got sum_valid=%b want 1", sum_valid2);
      end else begin
         e = exp2_q.pop_front();
         checks++;
         if ({2'b00, sum2} !== e.sum || overflow2 !== e.ovf) begin
            errors++;
            $display("[TB] FAIL ovf_result: got sum=%h ovf=%b want sum=%h ovf=%b", sum2, overflow2, e.sum, e.ovf);
         end
      end
      sum_ready2 = 1'b1;
      tick();
      sum_ready2 = 1'b0;
      checks++;
      if (overflow2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_sticky_idle: got %b want 1", overflow2);
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      checks++;
      if (overflow2 !== 1'b0 || sum2 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL ovf_cleared: got ovf=%b sum=%h want 0 0", overflow2, sum2);
      end
      prod2       = 16'h0003;
      prod_valid2 = 1'b1;
      tick();
      tick();
      prod_valid2 = 1'b0;
      checks++;
      if (sum2 !== 16'h0006 || overflow2 !== 1'b0 || sum_valid2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_small_sum: got sum=%h ovf=%b valid=%b want 0006 0 1", sum2, overflow2, sum_valid2);
      end
      sum_ready2 = 1'b1;
      tick();
      sum_ready2 = 1'b0;
   endtask

   // reset in the middle of a sum, then a fresh sum right after release
   task automatic test_mid_reset();
      exp_t e;
      ref_acc = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      feed(2, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (sum !== 18'h0 || {sum_valid, busy, prod_ready} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL midreset_async: got sum=%h valid/busy/ready=%b want 0 000", sum, {sum_valid, busy, prod_ready});
      end
      tick();
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || sum !== 18'h0) begin
         errors++;
         $display("[TB] FAIL midreset_first_start: got busy=%b sum=%h want 1 0", busy, sum);
      end
      ref_acc = 64'd0;
      feed(4, 1, 1'b1);
      checks++;
      if (sum_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL midreset_valid: got sum_valid=%b want 1", sum_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (sum !== e.sum || overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL midreset_result: got sum=%h ovf=%b want sum=%h ovf=%b", sum, overflow, e.sum, e.ovf);
         end
      end
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
   endtask

   initial begin
      prods[0]    = 16'h0000;
      prods[1]    = 16'h00C3;
      prods[2]    = 16'h0082;
      prods[3]    = 16'hFE01;
      rst_n       = 1'b1;
      start       = 1'b0;
      prod        = 16'h0;
      prod_valid  = 1'b0;
      sum_ready   = 1'b0;
      start2      = 1'b0;
      prod2       = 16'h0;
      prod_valid2 = 1'b0;
      sum_ready2  = 1'b0;
      ref_acc     = 64'd0;

      test_reset();
      test_basic();
      test_bubbles();
      test_back_pressure();
      test_ignored_start();
      test_overflow();
      test_mid_reset();

      checks++;
      if (exp_q.size() != 0 || exp2_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending want 0/0", exp_q.size(), exp2_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
